id_ex_stage: RTL and testbench

- ID/EX pipeline register of the pipelined MIPS core, directly downstream of the register file.
- Latches the RS/RT read data, decoded instruction fields and the control bundle for the EX stage.
- Detects load-use hazards and inserts one bubble per hazard. Honours branch flush and downstream hold.
- Keeps a saturating bubble counter for performance debug.

---
 rtl/id_ex_stage.sv | 121 ++++++++++++
 tb/tb_id_ex_stage.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ----------------------------------------------------------------------------
// id_ex_stage
//   ID/EX pipeline register of the pipelined MIPS core. It latches the
//   register-file operands, the decoded instruction fields and the control
//   bundle for EX. It inserts one bubble per load-use hazard, honours branch
//   flush and EX hold, and keeps a saturating bubble counter for perf debug.
//
//   Optional feature: define ID_EX_WB_BYPASS_EN to bypass write-back data
//   into the captured RS/RT operands. This covers the same-cycle
//   register-file write-then-read gap.
//
// Ports
//   clk_i, rst_i            clock, async active-low reset
//   id_*_i                  ID-stage instruction, PC+4, control and valid
//   rs_data_i, rt_data_i    register file read data
//   wb_we_i/addr_i/data_i   write-back port (used only by the bypass)
//   flush_i, ex_hold_i      branch kill, EX stall
//   ex_*_o                  registered EX-stage payload
//   hazard_stall_o          load-use stall to PC / IF-ID (combinational)
//   bubble_cnt_o            saturating count of inserted bubbles
// ----------------------------------------------------------------------------
module id_ex_stage #(
  parameter int unsigned CTRL_W      = 10,
  parameter int unsigned MEMREAD_BIT = 3,
  parameter int unsigned CNT_W       = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              id_valid_i,
  input  logic [31:0]       id_pc_plus4_i,
  input  logic [31:0]       id_instr_i,
  input  logic [CTRL_W-1:0] id_ctrl_i,
  input  logic [31:0]       rs_data_i,
  input  logic [31:0]       rt_data_i,
  input  logic              wb_we_i,
  input  logic [4:0]        wb_addr_i,
  input  logic [31:0]       wb_data_i,
  input  logic              flush_i,
  input  logic              ex_hold_i,
  output logic              ex_valid_o,
  output logic [31:0]       ex_pc_plus4_o,
  output logic [31:0]       ex_rs_data_o,
  output logic [31:0]       ex_rt_data_o,
  output logic [31:0]       ex_imm_o,
  output logic [4:0]        ex_rs_addr_o,
  output logic [4:0]        ex_rt_addr_o,
  output logic [4:0]        ex_rd_addr_o,
  output logic [CTRL_W-1:0] ex_ctrl_o,
  output logic              hazard_stall_o,
  output logic [CNT_W-1:0]  bubble_cnt_o
);

  localparam int unsigned REG_AW = 5;

  logic [REG_AW-1:0] id_rs_addr_c;
  logic [REG_AW-1:0] id_rt_addr_c;
  logic [31:0]       rs_capture_c;
  logic [31:0]       rt_capture_c;

  assign id_rs_addr_c = id_instr_i[25:21];
  assign id_rt_addr_c = id_instr_i[20:16];

  // Load in EX whose destination is read by ID. The RT match is made even for
  // instructions that ignore RT; the extra stall is harmless.
  assign hazard_stall_o = ex_valid_o && ex_ctrl_o[MEMREAD_BIT]
                       && (ex_rt_addr_o != REG_AW'(0))
                       && ((ex_rt_addr_o == id_rs_addr_c) || (ex_rt_addr_o == id_rt_addr_c))
                       && id_valid_i && !flush_i && !ex_hold_i;

`ifdef ID_EX_WB_BYPASS_EN
  // Write-back lands in the register file on the same edge we capture, so
  // take the write data directly. Register 0 is never a bypass source.
  assign rs_capture_c = (wb_we_i && (wb_addr_i != REG_AW'(0)) && (wb_addr_i == id_rs_addr_c))
                      ? wb_data_i : rs_data_i;
  assign rt_capture_c = (wb_we_i && (wb_addr_i != REG_AW'(0)) && (wb_addr_i == id_rt_addr_c))
                      ? wb_data_i : rt_data_i;
`else
  logic unused_wb;
  assign unused_wb    = ^{wb_we_i, wb_addr_i, wb_data_i};
  assign rs_capture_c = rs_data_i;
  assign rt_capture_c = rt_data_i;
`endif

  // Pipeline register: flush > hold > load-use bubble > normal load.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ex_valid_o    <= 1'b0;
      ex_pc_plus4_o <= 32'(0);
      ex_rs_data_o  <= 32'(0);
      ex_rt_data_o  <= 32'(0);
      ex_imm_o      <= 32'(0);
      ex_rs_addr_o  <= REG_AW'(0);
      ex_rt_addr_o  <= REG_AW'(0);
      ex_rd_addr_o  <= REG_AW'(0);
      ex_ctrl_o     <= CTRL_W'(0);
      bubble_cnt_o  <= CNT_W'(0);
    end else if (flush_i) begin
      ex_valid_o <= 1'b0;
      ex_ctrl_o  <= CTRL_W'(0);
    end else if (!ex_hold_i) begin
      if (hazard_stall_o) begin
        ex_valid_o <= 1'b0;
        ex_ctrl_o  <= CTRL_W'(0);
        if (bubble_cnt_o != {CNT_W{1'b1}}) begin
          bubble_cnt_o <= bubble_cnt_o + CNT_W'(1);
        end
      end else begin
        ex_valid_o    <= id_valid_i;
        ex_pc_plus4_o <= id_pc_plus4_i;
        ex_rs_data_o  <= rs_capture_c;
        ex_rt_data_o  <= rt_capture_c;
        ex_imm_o      <= {{16{id_instr_i[15]}}, id_instr_i[15:0]};
        ex_rs_addr_o  <= id_rs_addr_c;
        ex_rt_addr_o  <= id_rt_addr_c;
        ex_rd_addr_o  <= id_instr_i[15:11];
        ex_ctrl_o     <= id_valid_i ? id_ctrl_i : CTRL_W'(0);
      end
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// ----------------------------------------------------------------------------
// tb_id_ex_stage
//   Directed bench for id_ex_stage (instantiated with CNT_W=4 so that counter
//   saturation is reachable). Inputs change 1 time unit after the rising edge
//   and outputs are sampled there too.
// ----------------------------------------------------------------------------
module tb_id_ex_stage;

  localparam int unsigned CTRL_W = 10;
  localparam int unsigned CNT_W  = 4;

  // lw $8, 4($29) ; add $9,$8,$10 ; lw $0,-4($29) ; add $9,$0,$0 ; add $7,$5,$6
  localparam logic [31:0] LW8    = 32'h8FA8_0004;
  localparam logic [31:0] ADD8   = 32'h010A_4820;
  localparam logic [31:0] LW0    = 32'h8FA0_FFFC;
  localparam logic [31:0] ADD00  = 32'h0000_4820;
  localparam logic [31:0] ADD56  = 32'h00A6_3820;
  localparam logic [CTRL_W-1:0] C_LW  = 10'h00B;
  localparam logic [CTRL_W-1:0] C_ADD = 10'h201;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              id_valid_i;
  logic [31:0]       id_pc_plus4_i;
  logic [31:0]       id_instr_i;
  logic [CTRL_W-1:0] id_ctrl_i;
  logic [31:0]       rs_data_i;
  logic [31:0]       rt_data_i;
  logic              wb_we_i;
  logic [4:0]        wb_addr_i;
  logic [31:0]       wb_data_i;
  logic              flush_i;
  logic              ex_hold_i;
  logic              ex_valid_o;
  logic [31:0]       ex_pc_plus4_o;
  logic [31:0]       ex_rs_data_o;
  logic [31:0]       ex_rt_data_o;
  logic [31:0]       ex_imm_o;
  logic [4:0]        ex_rs_addr_o;
  logic [4:0]        ex_rt_addr_o;
  logic [4:0]        ex_rd_addr_o;
  logic [CTRL_W-1:0] ex_ctrl_o;
  logic              hazard_stall_o;
  logic [CNT_W-1:0]  bubble_cnt_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  id_ex_stage #(.CTRL_W(CTRL_W), .MEMREAD_BIT(3), .CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .id_valid_i(id_valid_i),
    .id_pc_plus4_i(id_pc_plus4_i), .id_instr_i(id_instr_i), .id_ctrl_i(id_ctrl_i),
    .rs_data_i(rs_data_i), .rt_data_i(rt_data_i), .wb_we_i(wb_we_i),
    .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i), .flush_i(flush_i),
    .ex_hold_i(ex_hold_i), .ex_valid_o(ex_valid_o), .ex_pc_plus4_o(ex_pc_plus4_o),
    .ex_rs_data_o(ex_rs_data_o), .ex_rt_data_o(ex_rt_data_o), .ex_imm_o(ex_imm_o),
    .ex_rs_addr_o(ex_rs_addr_o), .ex_rt_addr_o(ex_rt_addr_o),
    .ex_rd_addr_o(ex_rd_addr_o), .ex_ctrl_o(ex_ctrl_o),
    .hazard_stall_o(hazard_stall_o), .bubble_cnt_o(bubble_cnt_o)
  );

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_id(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                          input logic [CTRL_W-1:0] c);
    id_valid_i    = v;
    id_pc_plus4_i = pc;
    id_instr_i    = ins;
    id_ctrl_i     = c;
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b0; flush_i = 1'b0; ex_hold_i = 1'b0;
    wb_we_i = 1'b0; wb_addr_i = 5'd0; wb_data_i = 32'd0;
    rs_data_i = 32'h1111_1111; rt_data_i = 32'h2222_2222;
    drive_id(1'b1, 32'h0000_0104, LW8, C_LW);
    step();
    n_cmp++;
    if ({ex_valid_o, ex_ctrl_o, bubble_cnt_o, hazard_stall_o, ex_rt_addr_o} !== '0) begin
      n_err++;
      $display("FAIL reset_state: valid=%b ctrl=%h cnt=%0d stall=%b rt=%0d, expected all 0",
               ex_valid_o, ex_ctrl_o, bubble_cnt_o, hazard_stall_o, ex_rt_addr_o);
    end
    rst_i = 1'b1;
  endtask

  task automatic test_load_use();
    drive_id(1'b1, 32'h0000_0104, LW8, C_LW);
    step();
    n_cmp++;
    if ({ex_valid_o, ex_ctrl_o, ex_rt_addr_o, ex_imm_o, ex_pc_plus4_o} !==
        {1'b1, C_LW, 5'd8, 32'h0000_0004, 32'h0000_0104}) begin
      n_err++;
      $display("FAIL lw_capture: valid=%b ctrl=%h rt=%0d imm=%h pc=%h, expected 1 00b 8 00000004 00000104",
               ex_valid_o, ex_ctrl_o, ex_rt_addr_o, ex_imm_o, ex_pc_plus4_o);
    end
    rs_data_i = 32'h0000_AAAA; rt_data_i = 32'h0000_BBBB;
    drive_id(1'b1, 32'h0000_0108, ADD8, C_ADD);
    n_cmp++;
    if (hazard_stall_o !== 1'b1) begin
      n_err++; $display("FAIL load_use_stall: got %b expected 1", hazard_stall_o);
    end
    step();
    n_cmp++;
    if ({ex_valid_o, ex_ctrl_o, bubble_cnt_o, hazard_stall_o} !== {1'b0, 10'h000, 4'd1, 1'b0}) begin
      n_err++;
      $display("FAIL bubble: valid=%b ctrl=%h cnt=%0d stall=%b, expected 0 000 1 0",
               ex_valid_o, ex_ctrl_o, bubble_cnt_o, hazard_stall_o);
    end
    step();
    n_cmp++;
    if ({ex_valid_o, ex_ctrl_o, ex_rs_addr_o, ex_rt_addr_o, ex_rd_addr_o, ex_imm_o,
         ex_rs_data_o, ex_rt_data_o, ex_pc_plus4_o} !==
        {1'b1, C_ADD, 5'd8, 5'd10, 5'd9, 32'h0000_4820, 32'h0000_AAAA, 32'h0000_BBBB, 32'h0000_0108}) begin
      n_err++;
      $display("FAIL add_after_bubble: valid=%b ctrl=%h rs=%0d rt=%0d rd=%0d imm=%h rsd=%h rtd=%h pc=%h",
               ex_valid_o, ex_ctrl_o, ex_rs_addr_o, ex_rt_addr_o, ex_rd_addr_o, ex_imm_o,
               ex_rs_data_o, ex_rt_data_o, ex_pc_plus4_o);
    end
    n_cmp++;
    if ({hazard_stall_o, bubble_cnt_o} !== {1'b0, 4'd1}) begin
      n_err++; $display("FAIL after_pair: stall=%b cnt=%0d expected 0 1", hazard_stall_o, bubble_cnt_o);
    end
  endtask

  task automatic test_no_false_hazard();
    drive_id(1'b1, 32'h0000_0200, LW0, C_LW);
    step();
    n_cmp++;
    if ({ex_imm_o, ex_rt_addr_o} !== {32'hFFFF_FFFC, 5'd0}) begin
      n_err++; $display("FAIL sign_extend: imm=%h rt=%0d expected fffffffc 0", ex_imm_o, ex_rt_addr_o);
    end
    drive_id(1'b1, 32'h0000_0204, ADD00, C_ADD);
    n_cmp++;
    if (hazard_stall_o !== 1'b0) begin
      n_err++; $display("FAIL r0_no_hazard: got %b expected 0", hazard_stall_o);
    end
    step();
    n_cmp++;
    if ({ex_valid_o, ex_ctrl_o, bubble_cnt_o} !== {1'b1, C_ADD, 4'd1}) begin
      n_err++;
      $display("FAIL r0_pass_through: valid=%b ctrl=%h cnt=%0d expected 1 201 1",
               ex_valid_o, ex_ctrl_o, bubble_cnt_o);
    end
  endtask

  task automatic test_hold_and_flush();
    // Hold: EX keeps the add while ID presents something else.
    drive_id(1'b1, 32'h0000_0300, LW8, C_LW);
    ex_hold_i = 1'b1;
    step();
    n_cmp++;
    if ({ex_valid_o, ex_ctrl_o, ex_pc_plus4_o} !== {1'b1, C_ADD, 32'h0000_0204}) begin
      n_err++;
      $display("FAIL hold: valid=%b ctrl=%h pc=%h expected 1 201 00000204", ex_valid_o, ex_ctrl_o, ex_pc_plus4_o);
    end
    // Load the lw, then check hold masks the hazard.
    ex_hold_i = 1'b0;
    step();
    drive_id(1'b1, 32'h0000_0304, ADD8, C_ADD);
    ex_hold_i = 1'b1;
    #1;
    n_cmp++;
    if (hazard_stall_o !== 1'b0) begin
      n_err++; $display("FAIL hold_masks_stall: got %b expected 0", hazard_stall_o);
    end
    // Flush wins over hold; not counted as a bubble.
    flush_i = 1'b1;
    #1;
    step();
    n_cmp++;
    if ({ex_valid_o, ex_ctrl_o, bubble_cnt_o} !== {1'b0, 10'h000, 4'd1}) begin
      n_err++;
      $display("FAIL flush_over_hold: valid=%b ctrl=%h cnt=%0d expected 0 000 1",
               ex_valid_o, ex_ctrl_o, bubble_cnt_o);
    end
    flush_i = 1'b0; ex_hold_i = 1'b0;
    // Invalid ID instruction: valid and ctrl both 0 even with nonzero ctrl in.
    drive_id(1'b0, 32'h0000_0308, ADD56, C_ADD);
    step();
    n_cmp++;
    if ({ex_valid_o, ex_ctrl_o} !== {1'b0, 10'h000}) begin
      n_err++; $display("FAIL invalid_id: valid=%b ctrl=%h expected 0 000", ex_valid_o, ex_ctrl_o);
    end
  endtask

  task automatic test_bypass();
    logic [31:0] exp_rs;
`ifdef ID_EX_WB_BYPASS_EN
    exp_rs = 32'h0000_1234;
`else
    exp_rs = 32'h0000_DEAD;
`endif
    rs_data_i = 32'h0000_DEAD; rt_data_i = 32'h0000_BEEF;
    wb_we_i = 1'b1; wb_addr_i = 5'd5; wb_data_i = 32'h0000_1234;
    drive_id(1'b1, 32'h0000_0400, ADD56, C_ADD);
    step();
    n_cmp++;
    if ({ex_rs_data_o, ex_rt_data_o} !== {exp_rs, 32'h0000_BEEF}) begin
      n_err++;
      $display("FAIL wb_bypass: rs=%h rt=%h expected %h 0000beef", ex_rs_data_o, ex_rt_data_o, exp_rs);
    end
    // Write-back to r0 never bypasses.
    wb_addr_i = 5'd0;
    drive_id(1'b1, 32'h0000_0404, ADD00, C_ADD);
    step();
    n_cmp++;
    if ({ex_rs_data_o, ex_rt_data_o} !== {32'h0000_DEAD, 32'h0000_BEEF}) begin
      n_err++;
      $display("FAIL wb_r0_no_bypass: rs=%h rt=%h expected 0000dead 0000beef", ex_rs_data_o, ex_rt_data_o);
    end
    wb_we_i = 1'b0;
  endtask

  task automatic test_saturation();
    for (int i = 1; i <= 20; i++) begin
      drive_id(1'b1, 32'h0000_0500, LW8, C_LW);
      step();
      drive_id(1'b1, 32'h0000_0504, ADD8, C_ADD);
      step();
      step();
      if (i == 5) begin
        n_cmp++;
        if (bubble_cnt_o !== 4'd6) begin
          n_err++; $display("FAIL cnt_increment: got %0d expected 6", bubble_cnt_o);
        end
      end
    end
    n_cmp++;
    if (bubble_cnt_o !== 4'd15) begin
      n_err++; $display("FAIL cnt_saturate: got %0d expected 15", bubble_cnt_o);
    end
  endtask

  task automatic test_reset_mid_stream();
    drive_id(1'b1, 32'h0000_0600, LW8, C_LW);
    step();
    n_cmp++;
    if (ex_valid_o !== 1'b1) begin
      n_err++; $display("FAIL pre_reset_valid: got %b expected 1", ex_valid_o);
    end
    drive_id(1'b1, 32'h0000_0604, ADD8, C_ADD);
    #2;
    rst_i = 1'b0;
    #1;
    n_cmp++;
    if ({ex_valid_o, ex_ctrl_o, bubble_cnt_o, hazard_stall_o, ex_pc_plus4_o, ex_rs_data_o,
         ex_rt_data_o, ex_imm_o, ex_rs_addr_o, ex_rt_addr_o, ex_rd_addr_o} !== '0) begin
      n_err++;
      $display("FAIL reset_mid_stream: valid=%b ctrl=%h cnt=%0d stall=%b pc=%h imm=%h, expected all 0",
               ex_valid_o, ex_ctrl_o, bubble_cnt_o, hazard_stall_o, ex_pc_plus4_o, ex_imm_o);
    end
    rst_i = 1'b1;
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_no_false_hazard();
    test_hold_and_flush();
    test_bypass();
    test_saturation();
    test_reset_mid_stream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
